// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;

endpackage : fetch_pkg

// File: rtl/fetch_pc_reg.sv
// Fetch program counter: loads a new value when enabled, returns to RESET_VEC on reset.
module fetch_pc_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_pc,
    output logic [WIDTH-1:0] pc
);

    logic [WIDTH-1:0] pc_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_reg <= RESET_VEC;
        end else if (load) begin
            pc_reg <= load_pc;
        end
    end

    assign pc = pc_reg;

endmodule : fetch_pc_reg

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: one outstanding imem request, one-entry output buffer to decode,
// trap/redirect handling with discard of an in-flight response.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = 32'h0000_0000,
    parameter logic [WIDTH-1:0] TRAP_VEC  = 32'h0000_0100
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             trap,
    input  logic             stall,
    output logic             if_valid,
    output logic [31:0]      if_instr,
    output logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] pc_out
);

    fetch_state_t     state_reg, state_next;
    logic             discard_reg, discard_next;
    logic             if_valid_reg, if_valid_next;
    logic [31:0]      if_instr_reg, if_instr_next;
    logic [WIDTH-1:0] if_pc_reg, if_pc_next;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_next;
    logic             pc_load;
    logic             redirect;
    logic [WIDTH-1:0] redirect_target;
    logic             unused_redirect_bits;

    // Targets are always word aligned; the low bits of redirect_pc carry no meaning.
    assign unused_redirect_bits = ^redirect_pc[1:0];
    assign redirect             = trap | redirect_valid;
    assign redirect_target      = trap ? TRAP_VEC : {redirect_pc[WIDTH-1:2], 2'b00};

    fetch_pc_reg #(
        .WIDTH     (WIDTH),
        .RESET_VEC (RESET_VEC)
    ) u_pc_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (pc_load),
        .load_pc (pc_next),
        .pc      (pc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            discard_reg  <= 1'b0;
            if_valid_reg <= 1'b0;
            if_instr_reg <= '0;
            if_pc_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            discard_reg  <= discard_next;
            if_valid_reg <= if_valid_next;
            if_instr_reg <= if_instr_next;
            if_pc_reg    <= if_pc_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        discard_next  = discard_reg;
        if_valid_next = if_valid_reg;
        if_instr_next = if_instr_reg;
        if_pc_next    = if_pc_reg;
        pc_next       = pc;
        pc_load       = 1'b0;

        unique case (state_reg)
            IDLE: begin
                state_next = REQ;
            end
            REQ: begin
                if (imem_gnt) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (discard_reg) begin
                        discard_next = 1'b0;
                        state_next   = REQ;
                    end else begin
                        if_instr_next = imem_rdata;
                        if_pc_next    = pc;
                        if_valid_next = 1'b1;
                        pc_next       = pc + WIDTH'(INSTR_BYTES);
                        pc_load       = 1'b1;
                        state_next    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (if_valid_reg && !stall) begin
                    if_valid_next = 1'b0;
                    state_next    = REQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A redirect overrides the sequential decisions above and flushes the output.
        if (redirect) begin
            pc_next       = redirect_target;
            pc_load       = 1'b1;
            if_valid_next = 1'b0;
            unique case (state_reg)
                IDLE, HOLD: begin
                    state_next   = REQ;
                    discard_next = 1'b0;
                end
                REQ: begin
                    // An accepted request still owes a response that must be dropped.
                    state_next   = imem_gnt ? WAIT : REQ;
                    discard_next = imem_gnt;
                end
                WAIT: begin
                    state_next   = imem_rvalid ? REQ : WAIT;
                    discard_next = !imem_rvalid;
                end
                default: begin
                    state_next   = IDLE;
                    discard_next = 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = (state_reg == REQ);
    assign imem_addr = pc;
    assign pc_out    = pc;
    assign if_valid  = if_valid_reg;
    assign if_instr  = if_instr_reg;
    assign if_pc     = if_pc_reg;

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, sequential fetch, stall, redirect, trap, wrap.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] pc_out;

    int checks = 0;
    int errors = 0;

    fetch_sequencer #(
        .WIDTH     (32),
        .RESET_VEC (32'h0000_0000),
        .TRAP_VEC  (32'h0000_0100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap           (trap),
        .stall          (stall),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .pc_out         (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation timeout");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full fetch from REQ state with pc = exp_pc; decode consumes immediately.
    task automatic do_fetch(input logic [31:0] exp_pc, input logic [31:0] word, input int gnt_delay);
        logic [31:0] nxt;
        nxt = exp_pc + 32'd4;
        check("fetch_req", {31'd0, imem_req}, 32'd1);
        check("fetch_addr", imem_addr, exp_pc);
        for (int i = 0; i < gnt_delay; i++) begin
            tick();
            check("addr_stable", imem_addr, exp_pc);
            check("req_stable", {31'd0, imem_req}, 32'd1);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        check("wait_no_req", {31'd0, imem_req}, 32'd0);
        check("wait_no_valid", {31'd0, if_valid}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        tick();
        imem_rvalid = 1'b0;
        check("hold_valid", {31'd0, if_valid}, 32'd1);
        check("hold_instr", if_instr, word);
        check("hold_pc", if_pc, exp_pc);
        check("hold_pc_out", pc_out, nxt);
        $display("fetch pc=%h instr=%h", if_pc, if_instr);
        tick();
        check("consumed", {31'd0, if_valid}, 32'd0);
        check("next_addr", imem_addr, nxt);
        check("next_req", {31'd0, imem_req}, 32'd1);
    endtask

    initial begin
        rst            = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        trap           = 1'b0;
        stall          = 1'b0;

        // 1: reset
        repeat (3) tick();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_instr", if_instr, 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_pc", pc_out, 32'h0);
        rst = 1'b1;
        check("cyc1_req", {31'd0, imem_req}, 32'd0);
        tick();
        check("cyc2_req", {31'd0, imem_req}, 32'd1);
        check("cyc2_addr", imem_addr, 32'h0);
        check("cyc2_valid", {31'd0, if_valid}, 32'd0);

        // 2: sequential fetches, including a delayed grant
        do_fetch(32'h0, 32'h0050_0093, 0);
        do_fetch(32'h4, 32'h0050_0093, 0);
        do_fetch(32'h8, 32'h1234_5678, 2);

        // 3: stall while the output buffer is full
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_0013;
        stall       = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", {31'd0, if_valid}, 32'd1);
            check("stall_instr", if_instr, 32'hCAFE_0013);
            check("stall_if_pc", if_pc, 32'hC);
            check("stall_no_req", {31'd0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        tick();
        check("unstall_valid", {31'd0, if_valid}, 32'd0);
        check("unstall_addr", imem_addr, 32'h10);
        check("unstall_req", {31'd0, imem_req}, 32'd1);

        // 4: redirect while waiting for data
        imem_gnt = 1'b1;
        tick();
        imem_gnt       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        tick();
        redirect_valid = 1'b0;
        check("rdw_pc", pc_out, 32'h200);
        check("rdw_no_req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        check("rdw_dropped", {31'd0, if_valid}, 32'd0);
        check("rdw_addr", imem_addr, 32'h200);
        check("rdw_req", {31'd0, imem_req}, 32'd1);

        // 5: trap beats redirect in the same cycle
        trap           = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        trap           = 1'b0;
        redirect_valid = 1'b0;
        check("trap_addr", imem_addr, 32'h100);
        check("trap_req", {31'd0, imem_req}, 32'd1);

        // redirect coincident with grant: response must still be dropped
        imem_gnt       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick();
        imem_gnt       = 1'b0;
        redirect_valid = 1'b0;
        check("rdg_no_req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        tick();
        imem_rvalid = 1'b0;
        check("rdg_dropped", {31'd0, if_valid}, 32'd0);
        check("rdg_addr", imem_addr, 32'h300);

        // redirect flushes a held instruction
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0013;
        stall       = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        check("flush_pre_valid", {31'd0, if_valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h402;
        tick();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        check("flush_valid", {31'd0, if_valid}, 32'd0);
        check("flush_addr", imem_addr, 32'h400);

        // 6: wrap at top of address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        do_fetch(32'hFFFF_FFFC, 32'h0000_006F, 1);

        // reset mid-transaction, then a late response arrives
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rst2_req", {31'd0, imem_req}, 32'd0);
        check("rst2_pc", pc_out, 32'h0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hFEED_FACE;
        tick();
        check("late_ignored", {31'd0, if_valid}, 32'd0);
        check("late_req", {31'd0, imem_req}, 32'd1);
        tick();
        imem_rvalid = 1'b0;
        check("stray_valid", {31'd0, if_valid}, 32'd0);
        check("stray_addr", imem_addr, 32'h0);
        do_fetch(32'h0, 32'h0050_0093, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fetch_sequencer
